cmos_frame_writer: RTL and testbench

Camera-side producer for the DDR3 write path. It samples the 8-bit DVP camera bus (`cam_vsync`, `cam_href`, `cam_data`) on `wr_clk` (pixel clock) and assembles byte pairs into 16-bit RGB565 pixels. It drives the `datain_valid`/`datain`/`wr_load` inputs of the DDR3 FIFO controller. It suppresses the first frames after reset until the sensor is stable, and it checks the frame geometry.

---
 rtl/cmos_pkg.sv | 22 ++
 rtl/cmos_sync_edge.sv | 41 ++++
 rtl/cmos_frame_writer.sv | 121 ++++++++++++
 tb/tb_cmos_frame_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_pkg.sv
// Shared types and constants for the DVP camera capture path.
// Imported by the edge-detect stage and the frame writer.
package cmos_pkg;

    typedef enum logic [1:0] {
        WAIT_STABLE,
        WAIT_FRAME,
        ACTIVE
    } cap_state_t;

    localparam int H_PIXEL_DEF     = 640;
    localparam int V_PIXEL_DEF     = 480;
    localparam int WAIT_FRAMES_DEF = 10;
    localparam int CNT_W           = 11;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cmos_sync_edge.sv
// Registers the camera bus once and derives frame/line edges.
// vsync is held for one extra cycle so both of its edges are visible.
module cmos_sync_edge (
    input  logic       wr_clk,
    input  logic       rst_n,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       href_d0,
    output logic [7:0] data_d0,
    output logic       vs_rise,
    output logic       vs_fall,
    output logic       href_fall
);

    logic vsync_d0;
    logic vsync_d1;
    logic href_d1;

    // Input capture stage plus history bits for edge detection
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d0 <= 1'b0;
            vsync_d1 <= 1'b0;
            href_d0  <= 1'b0;
            href_d1  <= 1'b0;
            data_d0  <= 8'h00;
        end else begin
            vsync_d0 <= cam_vsync;
            vsync_d1 <= vsync_d0;
            href_d0  <= cam_href;
            href_d1  <= href_d0;
            data_d0  <= cam_data;
        end
    end

    assign vs_rise   = vsync_d0 & ~vsync_d1;
    assign vs_fall   = ~vsync_d0 & vsync_d1;
    assign href_fall = ~href_d0 & href_d1;

endmodule

// File: rtl/cmos_frame_writer.sv
// Camera-side producer: pairs DVP bytes into RGB565 pixels,
// skips start-up frames and flags frames with bad geometry.
module cmos_frame_writer
    import cmos_pkg::*;
#(
    parameter int WAIT_FRAMES = WAIT_FRAMES_DEF,
    parameter int H_PIXEL     = H_PIXEL_DEF,
    parameter int V_PIXEL     = V_PIXEL_DEF
) (
    input  logic        wr_clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        wr_load,
    output logic        datain_valid,
    output logic [15:0] datain,
    output logic        frame_done,
    output logic        frame_err,
    output logic        cap_en
);

    logic             href_d0;
    logic [7:0]       data_d0;
    logic             vs_rise;
    logic             vs_fall;
    logic             href_fall;

    cap_state_t       state;
    logic [3:0]       wait_cnt;
    logic             byte_sel;
    logic [7:0]       hi_byte;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;

    cmos_sync_edge u_sync (
        .wr_clk    (wr_clk),
        .rst_n     (rst_n),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .href_d0   (href_d0),
        .data_d0   (data_d0),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall),
        .href_fall (href_fall)
    );

    // Capture FSM with byte pairing and geometry checks
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_STABLE;
            wait_cnt     <= 4'd0;
            cap_en       <= 1'b0;
            wr_load      <= 1'b0;
            datain_valid <= 1'b0;
            datain       <= 16'h0000;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            byte_sel     <= 1'b0;
            hi_byte      <= 8'h00;
            pix_cnt      <= '0;
            line_cnt     <= '0;
        end else begin
            wr_load      <= 1'b0;
            datain_valid <= 1'b0;
            frame_done   <= 1'b0;
            unique case (state)
                WAIT_STABLE: begin
                    if (vs_rise) begin
                        if (wait_cnt == 4'(WAIT_FRAMES - 1)) begin
                            cap_en <= 1'b1;
                            state  <= WAIT_FRAME;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                end
                WAIT_FRAME: begin
                    byte_sel <= 1'b0;
                    if (vs_fall) begin
                        wr_load   <= 1'b1;
                        frame_err <= 1'b0;
                        pix_cnt   <= '0;
                        line_cnt  <= '0;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        // a line still open at frame end is truncated
                        frame_done <= 1'b1;
                        byte_sel   <= 1'b0;
                        if (line_cnt != CNT_W'(V_PIXEL) || href_d0)
                            frame_err <= 1'b1;
                        state <= WAIT_FRAME;
                    end else if (href_d0) begin
                        byte_sel <= ~byte_sel;
                        if (!byte_sel) begin
                            hi_byte <= data_d0;
                        end else begin
                            datain       <= {hi_byte, data_d0};
                            datain_valid <= 1'b1;
                            pix_cnt      <= sat_inc(pix_cnt);
                        end
                    end else begin
                        byte_sel <= 1'b0;
                        if (href_fall) begin
                            if (pix_cnt != CNT_W'(H_PIXEL) || byte_sel)
                                frame_err <= 1'b1;
                            line_cnt <= sat_inc(line_cnt);
                            pix_cnt  <= '0;
                        end
                    end
                end
                default: state <= WAIT_STABLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_frame_writer.sv
// Directed bench for cmos_frame_writer with a pixel scoreboard.
// Expected pixels and arrival cycles are queued as bytes are driven.
module tb_cmos_frame_writer;

    logic        wr_clk = 1'b0;
    logic        rst_n;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        wr_load;
    logic        datain_valid;
    logic [15:0] datain;
    logic        frame_done;
    logic        frame_err;
    logic        cap_en;

    cmos_frame_writer #(
        .WAIT_FRAMES (2),
        .H_PIXEL     (16),
        .V_PIXEL     (2)
    ) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .wr_load      (wr_load),
        .datain_valid (datain_valid),
        .datain       (datain),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .cap_en       (cap_en)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [15:0] d;
        int          t;
    } exp_t;

    exp_t     exp_q[$];
    int       cyc = 0;
    int       n_vec = 0;
    int       n_err = 0;
    int       wl_cnt = 0;
    int       fd_cnt = 0;
    int       pv_cnt = 0;
    int       viol = 0;
    logic [7:0] bval = 8'h12;

    always @(posedge wr_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Output monitor: pulse counters and scoreboard pops
    always @(negedge wr_clk) begin
        if (wr_load) wl_cnt++;
        if (frame_done) fd_cnt++;
        if (datain_valid && (wr_load || frame_done)) viol++;
        if (datain_valid) begin
            pv_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pixel", int'(datain), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pixel_data", int'(datain), int'(e.d));
                chk("pixel_cycle", cyc, e.t);
            end
        end
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send_line(input int nb, input bit cap, input bit close);
        logic [7:0] hi;
        hi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            tick();
            cam_href = 1'b1;
            cam_data = bval;
            if (i % 2 == 0) hi = bval;
            else if (cap) exp_q.push_back('{{hi, bval}, cyc + 2});
            bval = bval + 8'h22;
        end
        if (close) begin
            tick();
            cam_href = 1'b0;
            cam_data = 8'h00;
            repeat (4) tick();
        end
    endtask

    task automatic vs_set(input logic v);
        tick();
        cam_vsync = v;
        repeat (4) tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wr_load"}, int'(wr_load), 0);
        chk({tag, "_valid"}, int'(datain_valid), 0);
        chk({tag, "_datain"}, int'(datain), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_cap_en"}, int'(cap_en), 0);
    endtask

    int wl0;
    int fd0;

    initial begin
        rst_n     = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        repeat (3) tick();
        chk_reset_outs("reset");
        rst_n = 1'b1;

        // two discarded frames
        send_line(32, 0, 1);
        vs_set(1'b1);
        chk("stab_cap_en_early", int'(cap_en), 0);
        vs_set(1'b0);
        send_line(32, 0, 1);
        send_line(32, 0, 1);
        vs_set(1'b1);
        chk("stab_cap_en", int'(cap_en), 1);
        chk("stab_no_wr_load", wl_cnt, 0);
        chk("stab_no_pixels", pv_cnt, 0);

        // good frame
        vs_set(1'b0);
        chk("good_wr_load", wl_cnt, 1);
        bval = 8'h12;
        send_line(32, 1, 1);
        send_line(32, 1, 1);
        vs_set(1'b1);
        chk("good_frame_done", fd_cnt, 1);
        chk("good_frame_err", int'(frame_err), 0);
        chk("good_pixel_count", pv_cnt, 32);
        chk("good_queue_empty", exp_q.size(), 0);

        // short line
        vs_set(1'b0);
        chk("short_wr_load", wl_cnt, 2);
        send_line(32, 1, 1);
        chk("short_err_before", int'(frame_err), 0);
        send_line(30, 1, 1);
        chk("short_err_set", int'(frame_err), 1);
        vs_set(1'b1);
        chk("short_frame_done", fd_cnt, 2);
        chk("short_err_held", int'(frame_err), 1);
        vs_set(1'b0);
        chk("short_err_cleared", int'(frame_err), 0);

        // odd byte count
        send_line(31, 1, 1);
        chk("odd_err_set", int'(frame_err), 1);
        send_line(32, 1, 1);
        vs_set(1'b1);
        chk("odd_pixel_count", pv_cnt, 32 + 31 + 15 + 16);
        chk("odd_queue_empty", exp_q.size(), 0);
        vs_set(1'b0);
        chk("odd_err_cleared", int'(frame_err), 0);

        // vsync rises while href is high after 9 bytes
        send_line(32, 1, 1);
        fd0 = fd_cnt;
        send_line(9, 1, 0);
        tick();
        cam_vsync = 1'b1;
        cam_data  = bval;
        tick();
        cam_href = 1'b0;
        repeat (4) tick();
        chk("midvs_frame_done", fd_cnt, fd0 + 1);
        chk("midvs_frame_err", int'(frame_err), 1);
        chk("midvs_pixel_count", pv_cnt, 94 + 16 + 4);
        chk("midvs_queue_empty", exp_q.size(), 0);
        vs_set(1'b0);
        chk("midvs_err_cleared", int'(frame_err), 0);

        // reset in the middle of an active frame
        send_line(32, 1, 1);
        send_line(4, 1, 1);
        chk("rst_pre_err", int'(frame_err), 1);
        chk("rst_pre_queue", exp_q.size(), 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        repeat (3) tick();
        rst_n = 1'b1;
        wl0 = wl_cnt;
        send_line(32, 0, 1);
        vs_set(1'b1);
        vs_set(1'b0);
        chk("rst_stab_cap_en", int'(cap_en), 0);
        send_line(32, 0, 1);
        chk("rst_stab_no_load", wl_cnt, wl0);
        vs_set(1'b1);
        chk("rst_stab_cap_en2", int'(cap_en), 1);
        vs_set(1'b0);
        chk("rst_stab_wr_load", wl_cnt, wl0 + 1);

        repeat (4) tick();
        chk("valid_collision", viol, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
